rf_writeback_buffer: RTL
========================

// Module: rf_writeback_buffer
// PURPOSE
//  Write side of the 32x32 register file (ports WE3/A3/WD3). Queues retiring results (ALU, load)
//  in a small in-order FIFO and drains one entry per cycle into the register file write port.
//  Provides youngest-match bypass of queued values to the two read-port addresses (A1/A2) so the
//  decode stage never reads stale data while writes are pending.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >= 2
//  XLEN   32  data width
//  AW     5   register address width
// PORTS
//  clk       in   1              clock; all state updates on posedge
//  rst       in   1              synchronous, active-high reset
//  in_valid  in   1              result available for write-back
//  in_ready  out  1              buffer can accept; transfer when in_valid & in_ready
//  in_rd     in   AW             destination register
//  in_data   in   XLEN           result value
//  rf_hold   in   1              1 = write port unavailable this cycle; no drain
//  WE3       out  1              register file write enable
//  A3        out  AW             register file write address
//  WD3       out  XLEN           register file write data
//  lk_a1     in   AW             lookup address, read port 1
//  lk_a2     in   AW             lookup address, read port 2
//  hit1      out  1              queued entry matches lk_a1
//  hit2      out  1              queued entry matches lk_a2
//  fwd1      out  XLEN           bypass data for lk_a1 (youngest match)
//  fwd2      out  XLEN           bypass data for lk_a2 (youngest match)
//  count     out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (rst=1 at posedge): head/tail pointers and count cleared, all entries invalid; queued
//    writes discarded, never issued. While rst=1: in_ready=0, WE3=0. Outputs after reset: count=0,
//    WE3=0, A3=0, WD3=0, hit*=0, fwd*=0.
//  - in_ready = ~rst & (count != DEPTH); depends on count only, no same-cycle pass-through when full.
//  - Push: on in_valid & in_ready at posedge, {in_rd,in_data} written at tail, tail++ (wraps mod DEPTH).
//    in_rd==0 is accepted (handshake completes) but not enqueued; x0 is never written.
//  - Drain: WE3 = ~rst & (count!=0) & ~rf_hold (combinational); A3/WD3 = head entry when count!=0,
//    else 0. When WE3=1, the register file captures at the posedge and head++ at the same edge.
//  - Latency: entry pushed at edge N is presented at cycle N+1 (empty queue, rf_hold=0), landing in
//    the register file at edge N+1. Strict FIFO order; one write per cycle maximum.
//  - Simultaneous push and pop: count unchanged; legal at any count < DEPTH.
//  - Full with rf_hold=1: no push, no pop; state frozen.
//  - Bypass (combinational): hitN=1 iff lk_aN!=0 and any valid entry (including the head being
//    written this cycle) has rd==lk_aN; fwdN = data of youngest such entry, else 0. Same-cycle
//    in_data is not bypassed.
//  - count is registered; it never exceeds DEPTH nor underflows.
// TESTING
//  1. rst high 2 cycles, then low -> count=0, WE3=0, A3=0, in_ready=1.
//  2. Push rd=5,data=0x6 -> next cycle WE3=1,A3=5,WD3=0x6; following cycle WE3=0,count=0.
//  3. rf_hold=1, push rd=1..5 data=0x11..0x55 -> 4 accepted, count=4, in_ready=0, 5th held;
//     rf_hold=0 -> writes to r1,r2,r3,r4 on 4 consecutive cycles; r5 then accepted and written.
//  4. rf_hold=1, push rd=6/0xA then rd=6/0xB; lk_a1=6, lk_a2=0 -> hit1=1,fwd1=0xB, hit2=0,fwd2=0.
//  5. Push rd=0,data=0xDEAD -> handshake completes, count stays 0, WE3 never asserts.
//  6. rf_hold=1, 3 entries queued, rst pulsed 1 cycle -> count=0, no WE3 after rf_hold released.

Source files
------------

// File: rtl/rf_writeback_buffer.sv
// In-order write-back queue in front of the register file write port (WE3/A3/WD3),
// with youngest-match bypass of queued results to the two decode read addresses.
module rf_writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_rd,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       rf_hold,
    output logic                       WE3,
    output logic [AW-1:0]              A3,
    output logic [XLEN-1:0]            WD3,
    input  logic [AW-1:0]              lk_a1,
    input  logic [AW-1:0]              lk_a2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [XLEN-1:0]            fwd1,
    output logic [XLEN-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            nonempty;
    logic            full;
    logic            accept;
    logic            push;
    logic            pop;

    assign nonempty = (count != '0);
    assign full     = (count == CW'(DEPTH));

    // Ready is a function of occupancy only; a full queue never passes through.
    assign in_ready = ~rst & ~full;
    assign accept   = in_valid & in_ready;
    // Writes to x0 complete the handshake but are dropped here.
    assign push     = accept & (in_rd != '0);

    assign WE3 = ~rst & nonempty & ~rf_hold;
    assign pop = WE3;
    assign A3  = nonempty ? ent_rd[head]   : '0;
    assign WD3 = nonempty ? ent_data[head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[tail]   <= in_rd;
            ent_data[tail] <= in_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (lk_a1 != '0 && ent_rd[head + PW'(i)] == lk_a1) begin
                    hit1 = 1'b1;
                    fwd1 = ent_data[head + PW'(i)];
                end
                if (lk_a2 != '0 && ent_rd[head + PW'(i)] == lk_a2) begin
                    hit2 = 1'b1;
                    fwd2 = ent_data[head + PW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CW'(DEPTH))
                else $error("occupancy above DEPTH");
            assert (!(push && full))
                else $error("push into full queue");
            assert (!(pop && !nonempty))
                else $error("pop from empty queue");
        end
    end

endmodule
